// File: rtl/pdua_mem_pkg.sv
// ============================================================================
// Module      : pdua_mem_pkg
// Description : Shared types and constants for the memory bus sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdua_mem_pkg;

  localparam int WAIT_W = 4;
  localparam int TMO_W  = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_wait_cnt.sv
// ============================================================================
// Module      : mem_wait_cnt
// Description : Loadable down-counter with zero flag for memory wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_cnt
  import pdua_mem_pkg::*;
#(
  parameter int CNT_W = WAIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so a stray decrement never wraps into a long wait.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module      : mem_ctrl
// Description : Memory bus sequencer: setup / strobe / wait / ready / timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
  import pdua_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_req,
  input  logic                  wr_req,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT);

  logic [1:0]            state_q, state_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [TMO_W-1:0]      tmo_inc;
  logic                  wait_load;
  logic                  wait_dec;
  logic                  wait_zero;

  mem_wait_cnt #(
    .CNT_W (WAIT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load),
    .load_val (WAIT_LOAD),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  assign tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    wait_load = 1'b0;
    wait_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req || wr_req) begin
          op_d    = wr_req ? OP_WR : OP_RD;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_load = 1'b1;
        tmo_d     = '0;
        err_d     = 1'b0;
        state_d   = ST_STROBE;
      end
      ST_STROBE: begin
        // Ready only counts once the minimum wait states have elapsed.
        if (!wait_zero) begin
          wait_dec = 1'b1;
        end else if (mem_ready) begin
          state_d = ST_DONE;
          if (op_q == OP_RD) begin
            rdata_d = mem_rdata;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs decode registered state only, keeping the strobes glitch-free.
  assign busy      = (state_q == ST_SETUP) || (state_q == ST_STROBE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;
  assign mem_re    = (state_q == ST_STROBE) && (op_q == OP_RD);
  assign mem_we    = (state_q == ST_STROBE) && (op_q == OP_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl; two instances share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

  // Instance 0: WAIT_CYCLES=1, TIMEOUT=4.  Instance 1: WAIT_CYCLES=0, TIMEOUT=15.
  localparam int WAIT_A = 1;
  localparam int TMO_A  = 4;
  localparam int WAIT_B = 0;
  localparam int TMO_B  = 15;

  logic       clk;
  logic       rst;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       rd_req;
  logic       wr_req;
  logic [7:0] mem_rdata;
  logic       mem_ready;

  logic [1:0] busy_w, done_w, err_w, re_w, we_w;
  logic [3:0] maddr_w  [2];
  logic [7:0] mwdata_w [2];
  logic [7:0] rdata_w  [2];

  mem_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WAIT_CYCLES(WAIT_A), .TIMEOUT(TMO_A)) dut_a (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd_req(rd_req), .wr_req(wr_req),
    .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .rdata(rdata_w[0]),
    .mem_addr(maddr_w[0]), .mem_wdata(mwdata_w[0]), .mem_re(re_w[0]), .mem_we(we_w[0]),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WAIT_CYCLES(WAIT_B), .TIMEOUT(TMO_B)) dut_b (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd_req(rd_req), .wr_req(wr_req),
    .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .rdata(rdata_w[1]),
    .mem_addr(maddr_w[1]), .mem_wdata(mwdata_w[1]), .mem_re(re_w[1]), .mem_we(we_w[1]),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Transaction-level model: each transaction is described by its request
  // cycle and, once known, the cycle in which done must appear.
  bit         m_active [2];
  int         m_acc    [2];
  int         m_end    [2];
  int         m_miss   [2];
  bit         m_err    [2];
  logic       m_op     [2];
  logic [3:0] m_addr   [2];
  logic [7:0] m_wdata  [2];
  logic [7:0] m_rdata  [2];

  // Observation counters used by the directed literal checks.
  int re_cnt [2];
  int we_cnt [2];
  int done_cnt [2];
  int err_cnt [2];
  int err_alone [2];
  int last_done [2];
  int prev_done [2];

  function automatic int wait_of(int i);
    return (i == 0) ? WAIT_A : WAIT_B;
  endfunction

  function automatic int tmo_of(int i);
    return (i == 0) ? TMO_A : TMO_B;
  endfunction

  // 0 idle, 1 address setup, 2 strobing, 3 completion cycle
  function automatic int phase(int i);
    if (!m_active[i]) return 0;
    if (cyc == m_acc[i] + 1) return 1;
    if (m_end[i] >= 0 && cyc == m_end[i]) return 3;
    return 2;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int p;
      p = phase(i);
      if (rst) begin
        m_active[i] = 1'b0;
        m_err[i]    = 1'b0;
        m_op[i]     = 1'b0;
        m_addr[i]   = '0;
        m_wdata[i]  = '0;
        m_rdata[i]  = '0;
      end else if (p == 0) begin
        if (rd_req || wr_req) begin
          m_active[i] = 1'b1;
          m_acc[i]    = cyc;
          m_end[i]    = -1;
          m_miss[i]   = 0;
          m_err[i]    = 1'b0;
          m_op[i]     = wr_req;
          m_addr[i]   = addr;
          m_wdata[i]  = wdata;
        end
      end else if (p == 2) begin
        if (cyc >= m_acc[i] + 2 + wait_of(i)) begin
          if (mem_ready) begin
            m_end[i] = cyc + 1;
            if (!m_op[i]) m_rdata[i] = mem_rdata;
          end else begin
            m_miss[i]++;
            if (m_miss[i] == tmo_of(i)) begin
              m_end[i] = cyc + 1;
              m_err[i] = 1'b1;
            end
          end
        end
      end else if (p == 3) begin
        m_active[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int p;
      logic [24:0] exp_v, act_v;
      p = phase(i);
      exp_v = {(p == 1 || p == 2), (p == 3), (p == 3 && m_err[i]),
               (p == 2 && !m_op[i]), (p == 2 && m_op[i]),
               m_addr[i], m_wdata[i], m_rdata[i]};
      act_v = {busy_w[i], done_w[i], err_w[i], re_w[i], we_w[i],
               maddr_w[i], mwdata_w[i], rdata_w[i]};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model_cmp dut%0d cyc=%0d busy/done/err/re/we/addr/wdata/rdata act=%h exp=%h",
                 i, cyc, act_v, exp_v);
      end
      if (re_w[i] === 1'b1) re_cnt[i]++;
      if (we_w[i] === 1'b1) we_cnt[i]++;
      if (err_w[i] === 1'b1) err_cnt[i]++;
      if (err_w[i] === 1'b1 && done_w[i] !== 1'b1) err_alone[i]++;
      if (done_w[i] === 1'b1) begin
        done_cnt[i]++;
        prev_done[i] = last_done[i];
        last_done[i] = cyc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      re_cnt[i] = 0; we_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0;
      err_alone[i] = 0; last_done[i] = -100; prev_done[i] = -100;
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; addr = '0; wdata = '0; rd_req = 1'b0; wr_req = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;
    clr();
    tick(); tick();
    chk("reset_busy", int'(busy_w[0]), 0);
    chk("reset_rdata", int'(rdata_w[0]), 0);
    chk("reset_mem_addr", int'(maddr_w[0]), 0);
    rst = 1'b0;
    tick();

    // Read, ready high
    clr();
    t = cyc; addr = 4'hA; rd_req = 1'b1; mem_ready = 1'b1; mem_rdata = 8'h5C;
    tick(); rd_req = 1'b0;
    repeat (8) tick();
    chk("rd_done_lat_a", last_done[0] - t, 4);
    chk("rd_done_lat_b", last_done[1] - t, 3);
    chk("rd_re_cycles_a", re_cnt[0], 2);
    chk("rd_re_cycles_b", re_cnt[1], 1);
    chk("rd_rdata_a", int'(rdata_w[0]), 8'h5C);
    chk("rd_err_a", err_cnt[0], 0);

    // Write, memory not ready for 3 cycles after wait states
    clr();
    mem_ready = 1'b0;
    t = cyc; addr = 4'h3; wdata = 8'hE7; wr_req = 1'b1;
    tick(); wr_req = 1'b0;
    repeat (5) tick();
    mem_ready = 1'b1;
    repeat (6) tick();
    chk("wr_we_cycles_a", we_cnt[0], 5);
    chk("wr_we_cycles_b", we_cnt[1], 5);
    chk("wr_re_never_a", re_cnt[0], 0);
    chk("wr_done_lat_a", last_done[0] - t, 7);
    chk("wr_rdata_kept_a", int'(rdata_w[0]), 8'h5C);

    // Timeout with ready stuck low
    clr();
    mem_ready = 1'b0; mem_rdata = 8'h11;
    t = cyc; addr = 4'h6; rd_req = 1'b1;
    tick(); rd_req = 1'b0;
    repeat (22) tick();
    chk("tmo_done_cnt_a", done_cnt[0], 1);
    chk("tmo_err_cnt_a", err_cnt[0], 1);
    chk("tmo_err_alone_a", err_alone[0], 0);
    chk("tmo_done_lat_a", last_done[0] - t, 7);
    chk("tmo_done_lat_b", last_done[1] - t, 17);
    chk("tmo_rdata_kept_a", int'(rdata_w[0]), 8'h5C);
    chk("tmo_rdata_kept_b", int'(rdata_w[1]), 8'h5C);
    chk("tmo_idle_a", int'(busy_w[0]), 0);

    // Simultaneous requests, then a request while busy
    clr();
    mem_ready = 1'b1;
    t = cyc; addr = 4'h5; wdata = 8'h3C; rd_req = 1'b1; wr_req = 1'b1;
    tick(); rd_req = 1'b0; wr_req = 1'b0;
    tick(); rd_req = 1'b1;
    tick(); rd_req = 1'b0;
    repeat (6) tick();
    chk("both_done_cnt_a", done_cnt[0], 1);
    chk("both_we_cycles_a", we_cnt[0], 2);
    chk("both_re_never_a", re_cnt[0], 0);
    chk("both_done_cnt_b", done_cnt[1], 1);
    chk("both_wdata_a", int'(mwdata_w[0]), 8'h3C);

    // Reset in the middle of a strobe
    clr();
    mem_ready = 1'b0;
    t = cyc; addr = 4'h9; rd_req = 1'b1;
    tick(); rd_req = 1'b0;
    tick(); rst = 1'b1;
    tick();
    chk("rst_re_seen_a", re_cnt[0], 1);
    chk("rst_mem_re_a", int'(re_w[0]), 0);
    chk("rst_busy_a", int'(busy_w[0]), 0);
    chk("rst_rdata_a", int'(rdata_w[0]), 0);
    chk("rst_mem_addr_a", int'(maddr_w[0]), 0);
    rst = 1'b0;
    repeat (20) tick();
    chk("rst_no_done_a", done_cnt[0], 0);
    chk("rst_no_done_b", done_cnt[1], 0);

    // Back-to-back reads on the zero-wait instance
    clr();
    mem_ready = 1'b1; mem_rdata = 8'h77;
    t = cyc; addr = 4'h2; rd_req = 1'b1;
    tick(); rd_req = 1'b0;
    tick();
    tick(); rd_req = 1'b1;
    tick();
    tick(); rd_req = 1'b0;
    repeat (8) tick();
    chk("b2b_first_lat_b", prev_done[1] - t, 3);
    chk("b2b_spacing_b", last_done[1] - prev_done[1], 4);
    chk("b2b_done_cnt_b", done_cnt[1], 2);
    chk("b2b_done_cnt_a", done_cnt[0], 1);
    chk("b2b_rdata_b", int'(rdata_w[1]), 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
